load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  high only in IDLE; transfer when req_valid and req_ready both high.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-008 SHALL have port req_signed  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  load result; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  qualifies resp_valid; misaligned, out-of-range or illegal size.
REQ-014 SHALL have port mem_addr  output  32  word index into the memory.
REQ-015 SHALL have port mem_rbar_w  output  1  1 = write, 0 = read.
REQ-016 SHALL have port mem_wdata  output  32  memory write word.
REQ-017 SHALL have port mem_rdata  input  32  combinational memory read word.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, WRITE, RESP.
REQ-019 SHALL, on an IDLE handshake, latch the request, then go to RESP if it is an error, to WRITE if it is a word store, and otherwise to READ.
REQ-020 SHALL flag an error when any of these holds: halfword with addr[0]=1; word with addr[1:0]!=0; req_size=11; addr[31:2] >= MEM_WORDS.
REQ-021 SHALL drive mem_addr = {2'b00, addr[31:2]} from READ through the cycle after WRITE, and hold it stable across state changes.
REQ-022 SHALL, in READ, keep mem_rbar_w=0 and register mem_rdata at the cycle end.
REQ-023 SHALL, in READ for a load, extract the little-endian lane at addr[1:0] (byte 0 = bits 7:0), zero- or sign-extend it per req_signed, and go to RESP.
REQ-024 SHALL, in READ for a sub-word store, merge req_wdata into the addressed lane(s) of the read word and go to WRITE.
REQ-025 SHALL, in WRITE, assert mem_rbar_w=1 for exactly one cycle with mem_wdata and mem_addr already stable, then go to RESP.
REQ-026 SHALL, in RESP, assert resp_valid for one cycle with resp_rdata/resp_err, then return to IDLE.
REQ-027 SHALL meet these latencies from the accept edge to resp_valid: word store 2 cycles, load 2, sub-word store 3, error 1.
REQ-028 SHALL keep mem_rbar_w=0 for every error request.
REQ-029 SHALL ignore req_valid outside IDLE, with no queueing; the next request is accepted in the cycle after RESP.

Reset
REQ-030 SHALL, while reset is high, force state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_rbar_w=0, mem_addr=0, mem_wdata=0.
REQ-031 SHALL, on reset during READ, perform no write and issue no response.
REQ-032 SHALL, on reset during WRITE, deassert mem_rbar_w immediately; the write is treated as committed and no response is issued.
REQ-033 SHALL present req_ready=1 in the first cycle after reset is released.

Structure
REQ-034 SHALL place the state enum, the req_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and MEM_WORDS default in a shared package lsu_pkg.
REQ-035 SHALL place lane extract/merge in one combinational sub-module lsu_byte_lane; the FSM and registers stay in load_store_unit.

Verification
REQ-036 SHALL cover lw 0x10 on a freshly initialised memory (Mem[i]=i) -> mem_addr=4, resp_rdata=0x00000004 two cycles after accept, resp_err=0.
REQ-037 SHALL cover sw 0x123480FF to 0x20, then lb 0x21 (signed) and lbu 0x21 -> 0xFFFFFF80 and 0x00000080 respectively.
REQ-038 SHALL cover sh 0xBEEF to 0x0E (word 3 holds 3) -> one READ, then one WRITE with mem_wdata=0xBEEF0003, resp 3 cycles after accept; a following lw 0x0C -> 0xBEEF0003.
REQ-039 SHALL cover lw 0x02 and lw 0x400 -> resp_valid with resp_err=1, resp_rdata=0, one cycle after accept, mem_rbar_w never 1.
REQ-040 SHALL cover reset asserted in the READ cycle of sh 0x55 to 0x08 -> mem_rbar_w stays 0, no resp_valid, word 2 still 2, req_ready=1 after release.
REQ-041 SHALL cover req_valid held high through a word store -> exactly one accept per IDLE visit, and the second request is accepted in the cycle after RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 256;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane extraction for loads and lane merge for sub-word stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data  = rdata;
    merge_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{is_signed & byte_sel[7]}}, byte_sel};
        merge_data = rdata;
        unique case (addr_lo)
          2'd0:    merge_data[7:0]   = wdata[7:0];
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          default: merge_data[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        load_data  = {{16{is_signed & half_sel[15]}}, half_sel};
        merge_data = rdata;
        if (addr_lo[1]) begin
          merge_data[31:16] = wdata[15:0];
        end else begin
          merge_data[15:0] = wdata[15:0];
        end
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: byte/half/word accesses to a word memory,
// sub-word stores done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rbar_w,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        write_q, signed_q, err_q;
  logic [1:0]  size_q, addr_lo_q;
  logic [31:0] wdata_q, rdata_q, mem_addr_q, mem_wdata_q;

  logic        accept, misaligned, req_err;
  logic [31:0] word_idx, lane_load, lane_merge;

  assign accept   = req_valid && (state_q == IDLE);
  assign word_idx = {2'b00, req_addr[31:2]};

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;  // illegal size
    endcase
    req_err = misaligned || (word_idx >= MEM_WORDS);
  end

  lsu_byte_lane u_byte_lane (
    .rdata      (mem_rdata),
    .addr_lo    (addr_lo_q),
    .size       (size_q),
    .is_signed  (signed_q),
    .wdata      (wdata_q),
    .load_data  (lane_load),
    .merge_data (lane_merge)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = RESP;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:    state_d = write_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= SZ_BYTE;
      addr_lo_q   <= 2'b00;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (accept) begin
        write_q    <= req_write;
        signed_q   <= req_signed;
        err_q      <= req_err;
        size_q     <= req_size;
        addr_lo_q  <= req_addr[1:0];
        wdata_q    <= req_wdata;
        rdata_q    <= '0;
        mem_addr_q <= word_idx;
        if (req_write && (req_size == SZ_WORD) && !req_err) begin
          mem_wdata_q <= req_wdata;
        end
      end
      // Memory read data is only consumed at the end of the READ cycle.
      if (state_q == READ) begin
        if (write_q) begin
          mem_wdata_q <= lane_merge;
        end else begin
          rdata_q <= lane_load;
        end
      end
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = (state_q == RESP) ? rdata_q : '0;
    mem_rbar_w = (state_q == WRITE);
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
  end

endmodule
